fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Instruction fetch controller for the single-cycle instruction memory: owns the program counter and drives the memory address `cnt_out`. It captures the combinational `instruction` word into a registered output stage, presented to decode under a valid/ready handshake. It handles start/halt, branch redirect with flush, end-of-program detection and out-of-range targets.

Parameters:
AWIDTH, 8, address width of cnt_out / pc
DWIDTH, 32, instruction width
DEPTH, 32, number of valid instruction words (addresses 0..DEPTH-1)
RESET_PC, 0, start address loaded on start and after reset

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse: begin fetching at RESET_PC (IDLE or DONE only)
halt  input  1  abort fetch, flush output, return to IDLE
redirect_valid  input  1  branch/jump taken this cycle
redirect_pc  input  AWIDTH  redirect target word address
cnt_out  output  AWIDTH  address to instruction memory (= pc register)
instruction  input  DWIDTH  combinational read data from instruction memory
inst_out  output  DWIDTH  registered instruction to decode
pc_out  output  AWIDTH  address of inst_out
inst_valid  output  1  inst_out/pc_out valid
inst_ready  input  1  decode accepts when inst_valid && inst_ready
busy  output  1  state == FETCH
done  output  1  state == DONE and inst_valid == 0
range_err  output  1  sticky: redirect_pc >= DEPTH seen; cleared by start
stall_cnt  output  16  cycles in FETCH with inst_valid && !inst_ready (see Optional Feature)
fetch_cnt  output  16  instructions captured (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, inst_out=0, pc_out=0, inst_valid=0, range_err=0, counters=0.
- cnt_out is always the pc register. Memory read is combinational, so `instruction` is sampled in the same cycle.
- States: IDLE, FETCH, DONE.
- IDLE: inst_valid=0. start=1 -> pc<=RESET_PC, range_err<=0, FETCH next cycle.
- FETCH, capture condition = !inst_valid || inst_ready:
  - When capture holds: inst_out<=instruction, pc_out<=pc, inst_valid<=1, pc<=pc+1 (mod 2^AWIDTH).
  - When capture does not hold (stall): pc, inst_out, pc_out and inst_valid hold.
  - Latency: first inst_valid=1 two cycles after the start pulse. Throughput is 1 instruction/cycle while inst_ready=1.
- End of program: a capture at pc==DEPTH-1 moves to DONE. pc is not incremented. The captured word stays valid until accepted.
- DONE: no further captures. done=1 once the output drains. start=1 restarts as from IDLE.
- Redirect (FETCH or DONE), redirect_valid=1 with redirect_pc<DEPTH:
  - Next cycle: pc<=redirect_pc, inst_valid<=0 (flush, no capture this cycle), state<=FETCH.
  - First redirected instruction is valid 2 cycles after the redirect.
  - A handshake completing in the redirect cycle still counts as accepted.
- Redirect with redirect_pc>=DEPTH: range_err<=1, inst_valid<=0, state<=DONE, pc unchanged.
- Priority when simultaneous: halt > redirect > start > capture.
  - halt in any state: inst_valid<=0, state<=IDLE, pc<=RESET_PC; range_err keeps its value.
- redirect_valid in IDLE, and start in FETCH, are ignored.
- rst_n asserted mid-fetch: all outputs return to reset values immediately, regardless of clk.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - stall_cnt increments each FETCH cycle with inst_valid && !inst_ready.
  - fetch_cnt increments on each capture.
  - Both saturate at 16'hFFFF and clear on start and on reset.
- Undefined: no counter registers are built; stall_cnt and fetch_cnt are tied to 0.

Test Plan:
- Imem words 0..5 = 00007033, 00208433, 404404b3, 404404b3, 00317533, 0041e5b3; pulse start with inst_ready=1 -> inst_valid rises 2 cycles later; pc_out 0,1,2,3,4,5 appear on consecutive cycles with matching inst_out.
- Hold inst_ready=0 for 3 cycles while pc_out=2 is valid -> inst_out stays 404404b3 and cnt_out stays 3; on release, pc_out=3 follows next cycle. With FETCH_PERF_CNT_EN defined, stall_cnt=3.
- Redirect_valid with redirect_pc=1 while pc_out=4 is valid -> inst_valid=0 for one cycle, then pc_out=1 / 00208433.
- Run to address 31 -> state DONE, pc_out=31 valid until accepted, then done=1. A later start restarts at pc_out=0.
- redirect_pc=40 (DEPTH=32) -> range_err=1, done=1 next cycle; a subsequent start clears range_err.
- halt and redirect in the same cycle -> IDLE, inst_valid=0, cnt_out=RESET_PC. Drop rst_n mid-FETCH between clock edges -> outputs zero immediately.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch controller for a single-cycle instruction memory.
// Owns the program counter and presents the fetched word to decode through a
// registered valid/ready output stage. Supports start/halt, branch redirect with
// flush, end-of-program detection and out-of-range redirect reporting.
// Optional build macro FETCH_PERF_CNT_EN adds saturating stall/fetch counters;
// without it stall_cnt and fetch_cnt are tied to zero.
module fetch_sequencer #(
  parameter int AWIDTH   = 8,
  parameter int DWIDTH   = 32,
  parameter int DEPTH    = 32,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              halt,
  input  logic              redirect_valid,
  input  logic [AWIDTH-1:0] redirect_pc,
  output logic [AWIDTH-1:0] cnt_out,
  input  logic [DWIDTH-1:0] instruction,
  output logic [DWIDTH-1:0] inst_out,
  output logic [AWIDTH-1:0] pc_out,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic              busy,
  output logic              done,
  output logic              range_err,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       fetch_cnt
);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  // Highest legal word address; anything above it is out of range.
  localparam logic [AWIDTH-1:0] LAST_PC    = AWIDTH'(DEPTH - 1);
  localparam logic [AWIDTH-1:0] RESET_PC_W = AWIDTH'(RESET_PC);

  state_t              state_reg, state_next;
  logic [AWIDTH-1:0]   pc_reg, pc_next;
  logic [AWIDTH-1:0]   pc_out_reg, pc_out_next;
  logic [DWIDTH-1:0]   inst_reg, inst_next;
  logic                valid_reg, valid_next;
  logic                range_err_reg, range_err_next;
  logic                redirect_hit;
  logic                capture;

  // Redirects are only honoured once fetching has been started.
  assign redirect_hit = redirect_valid && (state_reg != IDLE);
  // Output stage can take a new word when empty or being drained this cycle.
  assign capture      = (state_reg == FETCH) && (!valid_reg || inst_ready);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      pc_reg        <= RESET_PC_W;
      pc_out_reg    <= '0;
      inst_reg      <= '0;
      valid_reg     <= 1'b0;
      range_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      pc_out_reg    <= pc_out_next;
      inst_reg      <= inst_next;
      valid_reg     <= valid_next;
      range_err_reg <= range_err_next;
    end
  end

  // Next-state logic; priority is halt > redirect > start > capture.
  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    pc_out_next    = pc_out_reg;
    inst_next      = inst_reg;
    valid_next     = valid_reg;
    range_err_next = range_err_reg;

    if (halt) begin
      state_next = IDLE;
      pc_next    = RESET_PC_W;
      valid_next = 1'b0;
    end else if (redirect_hit) begin
      valid_next = 1'b0;
      if (redirect_pc > LAST_PC) begin
        range_err_next = 1'b1;
        state_next     = DONE;
      end else begin
        pc_next    = redirect_pc;
        state_next = FETCH;
      end
    end else if (start && (state_reg != FETCH)) begin
      state_next     = FETCH;
      pc_next        = RESET_PC_W;
      range_err_next = 1'b0;
      valid_next     = 1'b0;
    end else if (capture) begin
      inst_next   = instruction;
      pc_out_next = pc_reg;
      valid_next  = 1'b1;
      if (pc_reg == LAST_PC) begin
        state_next = DONE;
      end else begin
        pc_next = pc_reg + 1'b1;
      end
    end else if ((state_reg == DONE) && valid_reg && inst_ready) begin
      valid_next = 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt_reg;
  logic [15:0] fetch_cnt_reg;
  logic        start_take;

  // A start only takes effect when nothing of higher priority is present.
  assign start_take = !halt && !redirect_hit && start && (state_reg != FETCH);

  // Saturating performance counters, cleared by an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
      fetch_cnt_reg <= '0;
    end else if (start_take) begin
      stall_cnt_reg <= '0;
      fetch_cnt_reg <= '0;
    end else begin
      if ((state_reg == FETCH) && valid_reg && !inst_ready && (stall_cnt_reg != 16'hFFFF))
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
      if (capture && !halt && !redirect_hit && (fetch_cnt_reg != 16'hFFFF))
        fetch_cnt_reg <= fetch_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign fetch_cnt = fetch_cnt_reg;
`else
  assign stall_cnt = '0;
  assign fetch_cnt = '0;
`endif

  assign cnt_out    = pc_reg;
  assign inst_out   = inst_reg;
  assign pc_out     = pc_out_reg;
  assign inst_valid = valid_reg;
  assign range_err  = range_err_reg;
  assign busy       = (state_reg == FETCH);
  assign done       = (state_reg == DONE) && !valid_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: self-checking bench for fetch_sequencer with a scoreboard of
// expected (pc, instruction) pairs popped on every decode handshake.
module tb_fetch_sequencer;
  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 32;

`ifdef FETCH_PERF_CNT_EN
  localparam int EXP_STALL   = 3;
  localparam int EXP_FETCH   = 36;
  localparam int EXP_FETCH_1 = 1;
`else
  localparam int EXP_STALL   = 0;
  localparam int EXP_FETCH   = 0;
  localparam int EXP_FETCH_1 = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, halt, redirect_valid, inst_ready;
  logic [AW-1:0] redirect_pc;
  logic [AW-1:0] cnt_out, pc_out;
  logic [DW-1:0] instruction, inst_out;
  logic          inst_valid, busy, done, range_err;
  logic [15:0]   stall_cnt, fetch_cnt;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] inst;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] imem [0:255];
  int          tests_run    = 0;
  int          tests_failed = 0;

  always #5 clk = ~clk;

  assign instruction = imem[cnt_out];

  fetch_sequencer #(.AWIDTH(AW), .DWIDTH(DW), .DEPTH(DEPTH), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .cnt_out(cnt_out), .instruction(instruction), .inst_out(inst_out),
    .pc_out(pc_out), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .busy(busy), .done(done), .range_err(range_err),
    .stall_cnt(stall_cnt), .fetch_cnt(fetch_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0h", tag, got);
    end
  endtask

  task automatic push(input int a);
    exp_t e;
    e.pc   = a[AW-1:0];
    e.inst = imem[a[7:0]];
    sb_q.push_back(e);
  endtask

  // Scores any handshake about to complete, then advances one clock to the next negedge.
  task automatic cycle();
    exp_t e;
    if (inst_valid && inst_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_extra", 64'(sb_q.size()), 64'd1);
      end else begin
        e = sb_q.pop_front();
        check("sb_pc", 64'(pc_out), 64'(e.pc));
        check("sb_inst", 64'(inst_out), 64'(e.inst));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) imem[i] = 32'hC0DE0000 | 32'(i);
    imem[0] = 32'h00007033; imem[1] = 32'h00208433; imem[2] = 32'h404404b3;
    imem[3] = 32'h404404b3; imem[4] = 32'h00317533; imem[5] = 32'h0041e5b3;

    rst_n = 1'b0; start = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; inst_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_valid", 64'(inst_valid), 64'd0);
    check("rst_cnt_out", 64'(cnt_out), 64'd0);
    check("rst_pc_out", 64'(pc_out), 64'd0);
    check("rst_inst_out", 64'(inst_out), 64'd0);
    check("rst_busy_done", 64'({busy, done, range_err}), 64'd0);
    rst_n = 1'b1;

    // Straight-line fetch from RESET_PC
    for (int a = 0; a <= 4; a++) push(a);
    inst_ready = 1'b1; start = 1'b1;
    cycle(); start = 1'b0;
    check("start_busy", 64'(busy), 64'd1);
    check("latency_not_yet", 64'(inst_valid), 64'd0);
    cycle();
    check("first_valid", 64'(inst_valid), 64'd1);
    check("first_pc", 64'(pc_out), 64'd0);
    cycle(); cycle();
    check("pc2_present", 64'(pc_out), 64'd2);

    // Stall three cycles with pc_out=2 held
    inst_ready = 1'b0;
    repeat (3) cycle();
    check("stall_inst", 64'(inst_out), 64'h404404b3);
    check("stall_pc_out", 64'(pc_out), 64'd2);
    check("stall_cnt_out", 64'(cnt_out), 64'd3);
    check("stall_cnt", 64'(stall_cnt), 64'(EXP_STALL));
    inst_ready = 1'b1;
    cycle();
    check("release_pc", 64'(pc_out), 64'd3);
    cycle();

    // Redirect to 1 while pc_out=4 is accepted
    check("pre_redir_pc", 64'(pc_out), 64'd4);
    redirect_valid = 1'b1; redirect_pc = 8'd1;
    cycle(); redirect_valid = 1'b0;
    check("flush_valid", 64'(inst_valid), 64'd0);
    check("flush_cnt_out", 64'(cnt_out), 64'd1);
    for (int a = 1; a <= 31; a++) push(a);
    cycle();
    check("redir_pc", 64'(pc_out), 64'd1);
    check("redir_inst", 64'(inst_out), 64'h00208433);

    // Run to end of program
    n = 0;
    while (!(inst_valid && pc_out == 8'd31) && n < 60) begin
      cycle();
      n++;
    end
    check("reached_last", 64'(inst_valid && pc_out == 8'd31), 64'd1);
    inst_ready = 1'b0;
    cycle(); cycle();
    check("done_busy", 64'(busy), 64'd0);
    check("done_hold_valid", 64'(inst_valid), 64'd1);
    check("done_hold_pc", 64'(pc_out), 64'd31);
    check("done_not_drained", 64'(done), 64'd0);
    check("done_cnt_out", 64'(cnt_out), 64'd31);
    check("fetch_cnt", 64'(fetch_cnt), 64'(EXP_FETCH));
    check("stall_cnt_end", 64'(stall_cnt), 64'(EXP_STALL));
    inst_ready = 1'b1;
    cycle();
    check("done_flag", 64'(done), 64'd1);
    check("done_drained", 64'(inst_valid), 64'd0);

    // Restart from DONE
    push(0); push(1);
    start = 1'b1;
    cycle(); start = 1'b0;
    check("restart_busy", 64'(busy), 64'd1);
    check("restart_cnt_out", 64'(cnt_out), 64'd0);
    cycle();
    check("restart_pc", 64'(pc_out), 64'd0);
    check("restart_fetch_cnt", 64'(fetch_cnt), 64'(EXP_FETCH_1));
    cycle();

    // Out-of-range redirect
    redirect_valid = 1'b1; redirect_pc = 8'd40;
    cycle(); redirect_valid = 1'b0;
    check("range_err_set", 64'(range_err), 64'd1);
    check("range_done", 64'(done), 64'd1);
    check("range_valid", 64'(inst_valid), 64'd0);
    check("range_pc_kept", 64'(cnt_out), 64'd2);
    start = 1'b1;
    cycle(); start = 1'b0;
    check("range_err_clr", 64'(range_err), 64'd0);

    // Halt and redirect together: halt wins
    push(0); push(1);
    cycle(); cycle(); cycle();
    inst_ready = 1'b0; halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'd5;
    cycle(); halt = 1'b0; redirect_valid = 1'b0;
    check("halt_busy", 64'(busy), 64'd0);
    check("halt_valid", 64'(inst_valid), 64'd0);
    check("halt_cnt_out", 64'(cnt_out), 64'd0);
    check("halt_done", 64'(done), 64'd0);

    // Asynchronous reset between clock edges
    inst_ready = 1'b1; start = 1'b1;
    cycle(); start = 1'b0;
    push(0); push(1);
    cycle(); cycle(); cycle();
    check("pre_reset_valid", 64'(inst_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", 64'(inst_valid), 64'd0);
    check("async_outs", 64'({pc_out, cnt_out, busy}), 64'd0);
    check("async_inst", 64'(inst_out), 64'd0);
    check("async_cnts", 64'({stall_cnt, fetch_cnt}), 64'd0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    check("sb_drain", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
